// File: rtl/fpu_alu_seq.sv
// Handshaked integer ALU with iterative radix-2 multiply and restoring divide.
// One operation at a time; results land in a registered valid/ready output slot.
module fpu_alu_seq #(
  parameter int WIDTH      = 64,
  parameter int ENABLE_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a_operand,
  input  logic [WIDTH-1:0] b_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Output,
  output logic [WIDTH-1:0] ALU_Output_Hi,
  output logic             Exception,
  output logic             Overflow,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam bit DIV_EN = (ENABLE_DIV != 0);
  localparam logic [SW-1:0] CNT_INIT = SW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             exc_q, exc_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic             in_ready_s;
  logic             accept_s;
  logic [SW-1:0]    shamt_s;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] sc_res_s;
  logic [WIDTH-1:0] sc_hi_s;
  logic             sc_exc_s;
  logic             sc_ovf_s;
  logic             start_mul_s;
  logic             start_div_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_diff_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_quo_s;

  assign in_ready_s = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign shamt_s    = b_operand[SW-1:0];
  assign add_s      = a_operand + b_operand;
  assign sub_s      = a_operand - b_operand;

  // Multiplier in acc_lo is consumed LSB-first while partial sums shift into it from the top.
  assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opa_q});
  assign div_diff_s  = div_shift_s[WIDTH-1:0] - opa_q;
  assign div_rem_s   = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
  assign div_quo_s   = {acc_lo_q[WIDTH-2:0], div_ge_s};

  // Decode the presented opcode into a single-cycle result or an engine start.
  always_comb begin
    sc_res_s    = '0;
    sc_hi_s     = '0;
    sc_exc_s    = 1'b0;
    sc_ovf_s    = 1'b0;
    start_mul_s = 1'b0;
    start_div_s = 1'b0;
    case (Operation)
      OP_ADD: begin
        sc_res_s = add_s;
        sc_ovf_s = (a_operand[WIDTH-1] == b_operand[WIDTH-1]) && (add_s[WIDTH-1] != a_operand[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_s = sub_s;
        sc_ovf_s = (a_operand[WIDTH-1] != b_operand[WIDTH-1]) && (sub_s[WIDTH-1] != a_operand[WIDTH-1]);
      end
      OP_MUL: start_mul_s = 1'b1;
      OP_DIV: begin
        if (!DIV_EN) begin
          sc_exc_s = 1'b1;
        end else if (b_operand == '0) begin
          sc_res_s = '1;
          sc_hi_s  = a_operand;
          sc_exc_s = 1'b1;
        end else begin
          start_div_s = 1'b1;
        end
      end
      OP_AND: sc_res_s = a_operand & b_operand;
      OP_OR:  sc_res_s = a_operand | b_operand;
      OP_XOR: sc_res_s = a_operand ^ b_operand;
      OP_NOT: sc_res_s = ~a_operand;
      OP_SHL: sc_res_s = a_operand << shamt_s;
      OP_SHR: sc_res_s = a_operand >> shamt_s;
      OP_SRA: sc_res_s = $unsigned($signed(a_operand) >>> shamt_s);
      default: sc_exc_s = 1'b1;
    endcase
  end

  // Next-state for the FSM, iterative engines and output slot.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    out_valid_d = out_valid_q && !out_ready;
    res_d       = res_q;
    res_hi_d    = res_hi_q;
    exc_d       = exc_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && start_mul_s) begin
          state_d  = S_MUL;
          cnt_d    = CNT_INIT;
          opa_d    = a_operand;
          acc_hi_d = '0;
          acc_lo_d = b_operand;
        end else if (accept_s && start_div_s) begin
          state_d  = S_DIV;
          cnt_d    = CNT_INIT;
          opa_d    = b_operand;
          acc_hi_d = '0;
          acc_lo_d = a_operand;
        end else if (accept_s) begin
          out_valid_d = 1'b1;
          res_d       = sc_res_s;
          res_hi_d    = sc_hi_s;
          exc_d       = sc_exc_s;
          ovf_d       = sc_ovf_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_hi_d = mul_sum_s[WIDTH:1];
        acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q - SW'(1);
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          res_d       = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
          res_hi_d    = mul_sum_s[WIDTH:1];
          exc_d       = 1'b0;
          ovf_d       = |mul_sum_s[WIDTH:1];
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        acc_hi_d = div_rem_s;
        acc_lo_d = div_quo_s;
        cnt_d    = cnt_q - SW'(1);
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          res_d       = div_quo_s;
          res_hi_d    = div_rem_s;
          exc_d       = 1'b0;
          ovf_d       = 1'b0;
        end else begin
          state_d = S_DIV;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_hi_q    <= '0;
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      res_hi_q    <= res_hi_d;
      exc_q       <= exc_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready      = in_ready_s;
  assign out_valid     = out_valid_q;
  assign ALU_Output    = res_q;
  assign ALU_Output_Hi = res_hi_q;
  assign Exception     = exc_q;
  assign Overflow      = ovf_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fpu_alu_seq.sv
// Bench for fpu_alu_seq at WIDTH=8: arithmetic reference model plus directed literal vectors.
module tb_fpu_alu_seq;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Operation;
  logic [W-1:0] a_operand;
  logic [W-1:0] b_operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Output;
  logic [W-1:0] ALU_Output_Hi;
  logic         Exception;
  logic         Overflow;
  logic         busy;

  fpu_alu_seq #(.WIDTH(W), .ENABLE_DIV(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .a_operand(a_operand), .b_operand(b_operand),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_Output(ALU_Output),
    .ALU_Output_Hi(ALU_Output_Hi), .Exception(Exception), .Overflow(Overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic       exc;
    logic       ovf;
    logic       multi;
  } res_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic       exc;
    logic       ovf;
    int         lat;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  logic chk_en = 1'b0;

  // Reference model state: cycles left in an engine, pending result, visible slot.
  int   m_rem = 0;
  res_t m_pend;
  logic m_ov = 1'b0;
  logic [7:0] m_res = 8'h00;
  logic [7:0] m_hi = 8'h00;
  logic m_exc = 1'b0;
  logic m_ovf = 1'b0;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t golden(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    res_t g;
    int sa, sb, r, p;
    g.res = 8'h00; g.hi = 8'h00; g.exc = 1'b0; g.ovf = 1'b0; g.multi = 1'b0;
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    case (op)
      4'd1: begin r = sa + sb; g.res = a + b; g.ovf = (r > 127) || (r < -128); end
      4'd2: begin r = sa - sb; g.res = a - b; g.ovf = (r > 127) || (r < -128); end
      4'd3: begin p = int'(a) * int'(b); g.res = p[7:0]; g.hi = p[15:8]; g.ovf = (p > 255); g.multi = 1'b1; end
      4'd4: begin
        if (b == 8'h00) begin g.res = 8'hFF; g.hi = a; g.exc = 1'b1; end
        else begin g.res = a / b; g.hi = a % b; g.multi = 1'b1; end
      end
      4'd5: g.res = a & b;
      4'd6: g.res = a | b;
      4'd7: g.res = a ^ b;
      4'd8: g.res = ~a;
      4'd9: begin p = int'(a) << b[2:0]; g.res = p[7:0]; end
      4'd10: g.res = a >> b[2:0];
      4'd11: begin r = sa >>> b[2:0]; g.res = r[7:0]; end
      default: g.exc = 1'b1;
    endcase
    return g;
  endfunction

  task automatic model_load(input res_t g);
    m_ov = 1'b1; m_res = g.res; m_hi = g.hi; m_exc = g.exc; m_ovf = g.ovf;
  endtask

  task automatic model_step();
    res_t g;
    logic acc;
    if (reset) begin
      m_rem = 0; m_ov = 1'b0; m_res = 8'h00; m_hi = 8'h00; m_exc = 1'b0; m_ovf = 1'b0;
    end else begin
      acc = (m_rem == 0) && in_valid && (!m_ov || out_ready);
      if (m_ov && out_ready) m_ov = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) model_load(m_pend);
      end else if (acc) begin
        g = golden(Operation, a_operand, b_operand);
        if (g.multi) begin m_rem = W; m_pend = g; end
        else model_load(g);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #2;
  endtask

  // Compare every cycle, mid-period, against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, (m_rem == 0) && (!m_ov || out_ready));
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, m_rem != 0);
      if (m_ov) begin
        chk("res", ALU_Output, m_res);
        chk("res_hi", ALU_Output_Hi, m_hi);
        chk("exception", Exception, m_exc);
        chk("overflow", Overflow, m_ovf);
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] res, input logic [7:0] hi, input logic exc,
                              input logic ovf, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi; v.exc = exc; v.ovf = ovf; v.lat = lat;
    return v;
  endfunction

  task automatic do_op(input int idx, input vec_t v);
    int lat;
    out_ready = 1'b0;
    in_valid = 1'b1; Operation = v.op; a_operand = v.a; b_operand = v.b;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (lat == 4) begin
        in_valid = 1'b1; Operation = 4'd1; a_operand = ~v.a; b_operand = 8'h55;
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      lat++;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_out_valid", idx), out_valid, 1'b1);
    chk($sformatf("v%0d_res", idx), ALU_Output, v.res);
    chk($sformatf("v%0d_hi", idx), ALU_Output_Hi, v.hi);
    chk($sformatf("v%0d_exc", idx), Exception, v.exc);
    chk($sformatf("v%0d_ovf", idx), Overflow, v.ovf);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'd0; a_operand = 8'h00; b_operand = 8'h00;

    vecs.push_back(mk(4'd1,  8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1));
    vecs.push_back(mk(4'd2,  8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1));
    vecs.push_back(mk(4'd3,  8'hC8, 8'h03, 8'h58, 8'h02, 1'b0, 1'b1, 9));
    vecs.push_back(mk(4'd4,  8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9));
    vecs.push_back(mk(4'd4,  8'h35, 8'h00, 8'hFF, 8'h35, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd11, 8'h80, 8'h03, 8'hF0, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd10, 8'h80, 8'h03, 8'h10, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd9,  8'h81, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd13, 8'h5A, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd5,  8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd6,  8'hF0, 8'h3C, 8'hFC, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd7,  8'hF0, 8'h3C, 8'hCC, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd8,  8'hF0, 8'h3C, 8'h0F, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd1,  8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd2,  8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd0,  8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'd3,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1, 9));
    vecs.push_back(mk(4'd3,  8'h0F, 8'h0F, 8'hE1, 8'h00, 1'b0, 1'b0, 9));
    vecs.push_back(mk(4'd4,  8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 9));
    vecs.push_back(mk(4'd4,  8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 9));
    vecs.push_back(mk(4'd9,  8'h81, 8'h09, 8'h02, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd11, 8'h7F, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'd15, 8'hAA, 8'h55, 8'h00, 8'h00, 1'b1, 1'b0, 1));

    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res", ALU_Output, 8'h00);
    chk("rst_hi", ALU_Output_Hi, 8'h00);
    chk("rst_exc", Exception, 1'b0);
    chk("rst_ovf", Overflow, 1'b0);
    reset = 1'b0;
    cyc();
    chk("rst_in_ready", in_ready, 1'b1);

    foreach (vecs[i]) do_op(i, vecs[i]);

    // Backpressure: first result held while a second request waits.
    out_ready = 1'b0;
    in_valid = 1'b1; Operation = 4'd1; a_operand = 8'h10; b_operand = 8'h20;
    cyc();
    Operation = 4'd1; a_operand = 8'h01; b_operand = 8'h02;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_res", ALU_Output, 8'h30);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_new_valid", out_valid, 1'b1);
    chk("bp_new_res", ALU_Output, 8'h03);
    out_ready = 1'b1;
    cyc();

    // Reset in the middle of a divide: nothing from it may surface.
    in_valid = 1'b1; Operation = 4'd4; a_operand = 8'h64; b_operand = 8'h07;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    chk("div_busy_before_rst", busy, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0; out_ready = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_res", ALU_Output, 8'h00);
    chk("mid_rst_hi", ALU_Output_Hi, 8'h00);
    chk("mid_rst_exc", Exception, 1'b0);
    chk("mid_rst_ovf", Overflow, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 12; k++) cyc();
    chk("no_stale_valid", out_valid, 1'b0);

    do_op(100, mk(4'd1, 8'h22, 8'h11, 8'h33, 8'h00, 1'b0, 1'b0, 1));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_alu_seq.md
Name: fpu_alu_seq

Overview:
- Parametrised, handshaked successor to the fixed 64-bit ALU; the datapath width is set by WIDTH.
- Accepts one operation at a time over a valid/ready input interface and returns results through a registered valid/ready output slot.
- Adds multi-cycle iterative multiply and divide engines, variable shift amounts, high-half and remainder results, and per-result flags.
- Sits between the FPU issue logic and writeback; the FP add, mul and div units stay separate.

Parameters:
- WIDTH, 64, operand/result width (>=4, power of two).
- ENABLE_DIV, 1, when 0 the DIV opcode is treated as an illegal opcode.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- Operation  input  4  opcode.
- a_operand  input  WIDTH  operand A.
- b_operand  input  WIDTH  operand B; low log2(WIDTH) bits give the shift amount.
- out_valid  output  1  result slot full.
- out_ready  input  1  consumer takes the result.
- ALU_Output  output  WIDTH  primary result.
- ALU_Output_Hi  output  WIDTH  MUL high half / DIV remainder; 0 for other ops.
- Exception  output  1  illegal opcode or divide by zero.
- Overflow  output  1  signed ADD/SUB overflow, or MUL high half nonzero.
- busy  output  1  multi-cycle engine running.

Behaviour:
- Opcodes:
  - 1 ADD, 2 SUB, 3 MUL (unsigned), 4 DIV (unsigned), 5 AND, 6 OR, 7 XOR, 8 NOT a.
  - 9 SHL, 10 SHR logical, 11 SRA arithmetic; shift amount is b[log2(WIDTH)-1:0].
  - All others, including 0, are illegal.
- Reset: state=IDLE, counter=0, out_valid=0, ALU_Output=0, ALU_Output_Hi=0, Exception=0, Overflow=0, busy=0. An in-flight op is discarded with no output.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A new op may be accepted in the same cycle the old result is consumed.
  - Output fields are held stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads in the same edge.
- FSM states IDLE, MUL, DIV:
  - IDLE accepts an op.
  - Single-cycle ops, illegal ops and div-by-zero load the result slot at the accept edge (latency 1) and stay in IDLE.
  - MUL/DIV latch operands, set counter=WIDTH-1 and go to MUL/DIV with busy=1.
  - One iteration per cycle. When counter==0, the final iteration writes the result slot, sets out_valid and returns to IDLE.
  - Latency is WIDTH+1 edges from the accept edge to out_valid.
  - out_valid is always 0 while in MUL/DIV, so completion never collides with a full slot.
- MUL: radix-2 shift-add on a 2*WIDTH product. ALU_Output=product[WIDTH-1:0], ALU_Output_Hi=product[2W-1:W], Overflow=|hi.
- DIV: restoring division. ALU_Output=quotient, ALU_Output_Hi=remainder.
- Divide by zero (b==0): quotient all ones, remainder=a, Exception=1, latency 1.
- ADD/SUB: modulo 2^WIDTH. Overflow = signed two's-complement overflow (operand signs agree for ADD, or differ for SUB, and result sign differs from a).
- Illegal opcode: ALU_Output=0, ALU_Output_Hi=0, Exception=1, Overflow=0.
- Flags not defined for an op are 0.
- in_valid is ignored in all states other than IDLE. Operand or opcode changes after accept have no effect.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 -> ALU_Output=0x80, Overflow=1, out_valid one edge after accept. SUB 0x80-0x01 -> 0x7F, Overflow=1.
- MUL 200*3 -> ALU_Output=0x58, ALU_Output_Hi=0x02, Overflow=1, out_valid 9 edges after accept. in_ready=0 and busy=1 throughout; an in_valid pulse mid-op is ignored.
- DIV 100/7 -> ALU_Output=14, ALU_Output_Hi=2, Exception=0 after 9 edges. DIV 0x35/0 -> 0xFF, 0x35, Exception=1 after 1 edge.
- SRA 0x80 by b=0x03 -> 0xF0; SHR same -> 0x10; SHL 0x81 by 1 -> 0x02; opcode 13 -> Exception=1, result 0.
- Backpressure: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Then raise out_ready together with a new valid ADD -> the new op is accepted on that edge and out_valid stays 1 with the new result.
- Reset asserted 4 cycles into a DIV -> next cycle state IDLE, busy=0, out_valid=0, all outputs 0, in_ready=1; no stale result ever appears.
